mem_arbiter: RTL and testbench

//  Two-port arbiter and bus sequencer in front of the 32-bit main memory.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and main-memory bus around mem_arbiter.
// master = the arbiter's view; slave = the requesters and memory facing it.
interface mem_arbiter_if #(
    parameter int DW = 32
);
    // Handshake: a requester raises req as a level and holds it (with addr/we/wdata
    // stable at grant) until its ack; ack is a single-cycle completion pulse, and
    // the returned word is valid from the ack cycle until the next read on that port.
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic [DW-1:0] if_data;
    logic          if_ack;

    logic          dm_req;
    logic          dm_we;
    logic [DW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;

    logic          err;

    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_data, if_ack, dm_rdata, dm_ack, err, mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_data, if_ack, dm_rdata, dm_ack, err, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory between a read-only fetch port
// and a read/write data port; completion by fixed latency or by memory ack.
module mem_arbiter #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int MEM_LATENCY   = 1,
    parameter int ACK_ENABLE    = 0,
    parameter int TIMEOUT       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus,
    output logic [1:0]    dbg_state
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam bit         USE_ACK  = (ACK_ENABLE != 0);

    logic [1:0] state;
    logic [7:0] count;
    logic       last_dm;
    logic       gnt_dm;
    logic       gnt_we;

    logic                     any_req;
    logic                     pick_dm;
    logic                     timed_out;
    logic                     access_end;
    logic [DATAWIDTH_BUS-1:0] rd_word;

    assign dbg_state = state;

    always_comb begin
        any_req    = bus.if_req | bus.dm_req;
        // Under contention the port that was not served last wins.
        pick_dm    = bus.dm_req & (~bus.if_req | ~last_dm);
        timed_out  = USE_ACK && !bus.mem_ack && (count == TMO_LAST);
        access_end = USE_ACK ? (bus.mem_ack || (count == TMO_LAST)) : (count == LAT_LAST);
        rd_word    = timed_out ? '0 : bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            count         <= '0;
            last_dm       <= 1'b1;
            gnt_dm        <= 1'b0;
            gnt_we        <= 1'b0;
            bus.if_data   <= '0;
            bus.if_ack    <= 1'b0;
            bus.dm_rdata  <= '0;
            bus.dm_ack    <= 1'b0;
            bus.err       <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            bus.err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_dm        <= pick_dm;
                        last_dm       <= pick_dm;
                        gnt_we        <= pick_dm & bus.dm_we;
                        bus.mem_addr  <= pick_dm ? bus.dm_addr : bus.if_addr;
                        bus.mem_wdata <= pick_dm ? bus.dm_wdata : '0;
                        bus.mem_rd    <= ~(pick_dm & bus.dm_we);
                        bus.mem_wr    <= pick_dm & bus.dm_we;
                        count         <= '0;
                        state         <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (access_end) begin
                        if (!gnt_we) begin
                            if (gnt_dm) bus.dm_rdata <= rd_word;
                            else        bus.if_data  <= rd_word;
                        end
                        bus.mem_rd <= 1'b0;
                        bus.mem_wr <= 1'b0;
                        count      <= '0;
                        // Ack and err are registered here so they are high exactly during DONE.
                        bus.if_ack <= ~gnt_dm;
                        bus.dm_ack <= gnt_dm;
                        bus.err    <= timed_out;
                        state      <= S_DONE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: three instances (latency 1, latency 3,
// ack-driven with timeout), directed vectors plus a randomized transaction model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DW(32)) b1 ();
    mem_arbiter_if #(.DW(32)) b3 ();
    mem_arbiter_if #(.DW(32)) ba ();
    logic [1:0] st1, st3, sta;

    mem_arbiter #(.DATAWIDTH_BUS(32), .MEM_LATENCY(1), .ACK_ENABLE(0), .TIMEOUT(8))
        u_l1 (.clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(st1));
    mem_arbiter #(.DATAWIDTH_BUS(32), .MEM_LATENCY(3), .ACK_ENABLE(0), .TIMEOUT(8))
        u_l3 (.clk(clk), .rst_n(rst_n), .bus(b3), .dbg_state(st3));
    mem_arbiter #(.DATAWIDTH_BUS(32), .MEM_LATENCY(1), .ACK_ENABLE(1), .TIMEOUT(8))
        u_ack (.clk(clk), .rst_n(rst_n), .bus(ba), .dbg_state(sta));

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 32'h200) ? 32'hC600_2001 : (32'hA500_0000 | 32'(i));
    endfunction

    // Memory models: combinational read, write on any cycle with the strobe high.
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] mema [0:1023];
    bit mem_rdy = 1'b0;

    assign b1.mem_rdata = mem1[b1.mem_addr[11:2]];
    assign b3.mem_rdata = mem3[b3.mem_addr[11:2]];
    assign ba.mem_rdata = mema[ba.mem_addr[11:2]];

    always @(posedge clk) begin
        if (!mem_rdy) begin
            for (int i = 0; i < 1024; i++) begin
                mem1[i] <= init_word(i);
                mem3[i] <= init_word(i);
                mema[i] <= init_word(i);
            end
            mem_rdy <= 1'b1;
        end else begin
            if (b1.mem_wr) mem1[b1.mem_addr[11:2]] <= b1.mem_wdata;
            if (b3.mem_wr) mem3[b3.mem_addr[11:2]] <= b3.mem_wdata;
            if (ba.mem_wr) mema[ba.mem_addr[11:2]] <= ba.mem_wdata;
        end
    end

    // Ack-mode memory: raises ack in the ack_after-th strobe cycle (0 = never).
    int ack_after = 0;
    int acc_cnt = 0;
    always @(negedge clk) begin
        if (ba.mem_rd || ba.mem_wr) acc_cnt = acc_cnt + 1;
        else                        acc_cnt = 0;
        ba.mem_ack = (ack_after != 0) && (acc_cnt == ack_after);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        bit          dm;
        bit          we;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    vec_t        tbl [7];
    exp_t        eq [$];
    logic [31:0] ref_mem [16];
    int          lat, rd_n, wr_n, other_n, ack_n, next_free, idx;
    logic [31:0] s_addr, s_data, mdl_dm_rdata, e_data, p_data;
    logic [3:0]  ord;
    bit          last_dm, p_dm, p_we, e_if, e_dm, e_we, err_seen;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h800, 32'h0,         32'hC600_2001};
        tbl[1] = '{1'b1, 1'b1, 32'h804, 32'hDEAD_BEEF, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h804, 32'h0,         32'hDEAD_BEEF};
        tbl[3] = '{1'b0, 1'b0, 32'h804, 32'h0,         32'hDEAD_BEEF};
        tbl[4] = '{1'b1, 1'b1, 32'h808, 32'h0000_0001, 32'hDEAD_BEEF};
        tbl[5] = '{1'b1, 1'b0, 32'h80C, 32'h0,         32'hA500_0203};
        tbl[6] = '{1'b0, 1'b0, 32'h808, 32'h0,         32'h0000_0001};

        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0; b1.mem_ack = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = 0; b3.dm_wdata = 0; b3.mem_ack = 0;
        ba.if_req = 0; ba.if_addr = 0; ba.dm_req = 0; ba.dm_we = 0; ba.dm_addr = 0; ba.dm_wdata = 0;

        // Reset values on every instance.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_l1_data", {b1.if_data, b1.dm_rdata}, 64'h0);
        check("rst_l1_ctrl", {b1.mem_addr, st1, b1.mem_rd, b1.mem_wr, b1.if_ack, b1.dm_ack, b1.err}, 64'h0);
        check("rst_l3_ctrl", {b3.mem_addr, st3, b3.mem_rd, b3.mem_wr, b3.if_ack, b3.dm_ack, b3.err}, 64'h0);
        check("rst_ack_ctrl", {ba.mem_addr, sta, ba.mem_rd, ba.mem_wr, ba.if_ack, ba.dm_ack, ba.err}, 64'h0);
        rst_n = 1'b1;

        // Single transfers on the latency-1 instance.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (tbl[i].dm) begin
                b1.dm_req = 1; b1.dm_we = tbl[i].we; b1.dm_addr = tbl[i].addr; b1.dm_wdata = tbl[i].wdata;
            end else begin
                b1.if_req = 1; b1.if_addr = tbl[i].addr;
            end
            lat = 0; rd_n = 0; wr_n = 0; other_n = 0; s_addr = '0; s_data = '0;
            for (int c = 1; c <= 20 && lat == 0; c++) begin
                @(negedge clk);
                if (b1.mem_rd) rd_n++;
                if (b1.mem_wr) begin wr_n++; s_data = b1.mem_wdata; end
                if (b1.mem_rd || b1.mem_wr) s_addr = b1.mem_addr;
                if (tbl[i].dm ? b1.dm_ack : b1.if_ack) lat = c;
                if (tbl[i].dm ? b1.if_ack : b1.dm_ack) other_n++;
            end
            b1.if_req = 0; b1.dm_req = 0;
            check($sformatf("tbl%0d_ack_latency", i), 64'(lat), 64'd2);
            check($sformatf("tbl%0d_rd_cycles", i), 64'(rd_n), tbl[i].we ? 64'd0 : 64'd1);
            check($sformatf("tbl%0d_wr_cycles", i), 64'(wr_n), tbl[i].we ? 64'd1 : 64'd0);
            check($sformatf("tbl%0d_mem_addr", i), 64'(s_addr), 64'(tbl[i].addr));
            check($sformatf("tbl%0d_other_ack", i), 64'(other_n), 64'd0);
            if (tbl[i].we) check($sformatf("tbl%0d_mem_wdata", i), 64'(s_data), 64'(tbl[i].wdata));
            check($sformatf("tbl%0d_port_data", i), tbl[i].dm ? 64'(b1.dm_rdata) : 64'(b1.if_data),
                  64'(tbl[i].exp_data));
        end

        // Reset in the middle of a DM read: strobes drop at once and no ack follows.
        @(negedge clk);
        b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 32'h804;
        @(negedge clk);
        check("abort_rd_before", 64'(b1.mem_rd), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_strobes_async", {st1, b1.mem_rd, b1.mem_wr}, 64'h0);
        b1.dm_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_n = 0;
        repeat (3) begin
            @(negedge clk);
            if (b1.dm_ack || b1.if_ack) ack_n++;
        end
        check("abort_no_ack", 64'(ack_n), 64'd0);
        check("abort_state_idle", 64'(st1), 64'd0);

        // Contention with both requests held: IF first after reset, then alternation.
        b1.if_req = 1; b1.if_addr = 32'h800;
        b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 32'h804;
        ack_n = 0; ord = '0;
        for (int c = 0; c < 40 && ack_n < 4; c++) begin
            @(negedge clk);
            if (b1.if_ack || b1.dm_ack) begin
                ord[ack_n] = b1.dm_ack;
                if (b1.if_ack) check("rr_if_data", 64'(b1.if_data), 64'hC600_2001);
                if (b1.dm_ack) check("rr_dm_data", 64'(b1.dm_rdata), 64'hDEAD_BEEF);
                ack_n++;
            end
        end
        b1.if_req = 0; b1.dm_req = 0;
        check("rr_ack_count", 64'(ack_n), 64'd4);
        check("rr_order", 64'(ord), 64'b1010);

        // Latency-3 write: WR held three cycles, ack on the fourth, rdata untouched.
        @(negedge clk);
        b3.dm_req = 1; b3.dm_we = 1; b3.dm_addr = 32'h900; b3.dm_wdata = 32'h1234_5678;
        lat = 0; rd_n = 0; wr_n = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (b3.mem_rd) rd_n++;
            if (b3.mem_wr) begin
                wr_n++;
                check("wr3_addr", 64'(b3.mem_addr), 64'h900);
                check("wr3_data", 64'(b3.mem_wdata), 64'h1234_5678);
            end
            if (b3.dm_ack) lat = c;
        end
        b3.dm_req = 0;
        check("wr3_wr_cycles", 64'(wr_n), 64'd3);
        check("wr3_rd_cycles", 64'(rd_n), 64'd0);
        check("wr3_ack_latency", 64'(lat), 64'd4);
        check("wr3_rdata_kept", 64'(b3.dm_rdata), 64'h0);

        // IF withdraws its request right after the grant; the transfer still completes once.
        @(negedge clk);
        b3.if_req = 1; b3.if_addr = 32'h800;
        rd_n = 0; ack_n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) b3.if_req = 0;
            if (b3.mem_rd) rd_n++;
            if (b3.if_ack) ack_n++;
        end
        check("drop_rd_cycles", 64'(rd_n), 64'd3);
        check("drop_ack_count", 64'(ack_n), 64'd1);
        check("drop_if_data", 64'(b3.if_data), 64'hC600_2001);
        check("drop_state_idle", 64'(st3), 64'd0);

        // Ack-driven completion after two cycles.
        ack_after = 2;
        @(negedge clk);
        ba.if_req = 1; ba.if_addr = 32'h800;
        lat = 0; rd_n = 0; err_seen = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            if (ba.mem_rd) rd_n++;
            if (ba.if_ack) begin lat = c; err_seen = ba.err; ba.if_req = 0; end
        end
        check("ack2_rd_cycles", 64'(rd_n), 64'd2);
        check("ack2_latency", 64'(lat), 64'd3);
        check("ack2_err", 64'(err_seen), 64'd0);
        check("ack2_data", 64'(ba.if_data), 64'hC600_2001);

        // Memory never acks: forced completion after TIMEOUT cycles, data zeroed, err pulses once.
        ack_after = 0;
        @(negedge clk);
        ba.if_req = 1; ba.if_addr = 32'h804;
        lat = 0; rd_n = 0; err_seen = 0;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge clk);
            if (ba.mem_rd) rd_n++;
            if (ba.if_ack) begin lat = c; err_seen = ba.err; ba.if_req = 0; end
        end
        check("tmo_rd_cycles", 64'(rd_n), 64'd8);
        check("tmo_latency", 64'(lat), 64'd9);
        check("tmo_err", 64'(err_seen), 64'd1);
        check("tmo_data_zero", 64'(ba.if_data), 64'h0);
        @(negedge clk);
        check("tmo_err_one_cycle", {ba.err, ba.if_ack}, 64'h0);

        // Randomized traffic on the latency-3 instance against a transaction-level model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 16; j++) ref_mem[j] = init_word(32'h300 + j);
        last_dm = 1'b1;
        next_free = 0;
        mdl_dm_rdata = '0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            e_if = 0; e_dm = 0; e_we = 0; e_data = '0;
            if (eq.size() > 0 && eq[0].cyc == k) begin
                e_if = !eq[0].dm; e_dm = eq[0].dm; e_we = eq[0].we; e_data = eq[0].data;
                void'(eq.pop_front());
            end
            if (e_if || e_dm || b3.if_ack || b3.dm_ack) begin
                check("rnd_ack", {b3.if_ack, b3.dm_ack}, {e_if, e_dm});
                if (e_if) check("rnd_if_data", 64'(b3.if_data), 64'(e_data));
                if (e_dm) begin
                    if (!e_we) mdl_dm_rdata = e_data;
                    check("rnd_dm_rdata", 64'(b3.dm_rdata), 64'(mdl_dm_rdata));
                end
            end
            if (b3.mem_rd && b3.mem_wr) check("rnd_strobe_excl", 64'h3, 64'h1);

            if (b3.if_ack) b3.if_req = 0;
            else if (!b3.if_req && k < 2900 && $urandom_range(0, 3) == 0) begin
                b3.if_req = 1; b3.if_addr = 32'hC00 + 32'(4 * $urandom_range(0, 15));
            end
            if (b3.dm_ack) b3.dm_req = 0;
            else if (!b3.dm_req && k < 2900 && $urandom_range(0, 3) == 0) begin
                b3.dm_req = 1; b3.dm_we = 1'($urandom_range(0, 1));
                b3.dm_addr = 32'hC00 + 32'(4 * $urandom_range(0, 15)); b3.dm_wdata = $urandom;
            end

            // Serialized service: a grant every L+2 cycles at most, ack L+1 cycles after grant.
            if (k >= next_free && (b3.if_req || b3.dm_req)) begin
                p_dm = b3.dm_req && (!b3.if_req || !last_dm);
                p_we = p_dm && b3.dm_we;
                idx = p_dm ? int'(b3.dm_addr[5:2]) : int'(b3.if_addr[5:2]);
                if (p_we) ref_mem[idx] = b3.dm_wdata;
                p_data = ref_mem[idx];
                eq.push_back('{p_dm, p_we, k + 4, p_data});
                last_dm = p_dm;
                next_free = k + 5;
            end
        end
        check("rnd_queue_drained", 64'(eq.size()), 64'd0);
        check("rnd_reqs_idle", {b3.if_req, b3.dm_req, st3}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
